// File: rtl/keyboard_tracker_pkg.sv
// Shared definitions for the PS/2 keyboard tracker: scan-code set 2 constants,
// key indices and the scan-code to key decode.
package keyboard_tracker_pkg;

  localparam int unsigned NUM_KEYS = 10;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [3:0] {
    KEY_W     = 4'd0,
    KEY_A     = 4'd1,
    KEY_S     = 4'd2,
    KEY_D     = 4'd3,
    KEY_LEFT  = 4'd4,
    KEY_RIGHT = 4'd5,
    KEY_UP    = 4'd6,
    KEY_DOWN  = 4'd7,
    KEY_SPACE = 4'd8,
    KEY_ENTER = 4'd9
  } key_e;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Prefix state carried between bytes of one key event
  typedef struct packed {
    logic ext;
    logic brk;
  } prefix_t;

  // One-hot key for a non-prefix byte; arrows only count behind an E0 prefix
  function automatic key_vec_t key_mask(input logic [7:0] code, input logic ext);
    key_vec_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     m[KEY_W]     = 1'b1;
        SC_A:     m[KEY_A]     = 1'b1;
        SC_S:     m[KEY_S]     = 1'b1;
        SC_D:     m[KEY_D]     = 1'b1;
        SC_SPACE: m[KEY_SPACE] = 1'b1;
        SC_ENTER: m[KEY_ENTER] = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m[KEY_UP]    = 1'b1;
        SC_DOWN:  m[KEY_DOWN]  = 1'b1;
        SC_LEFT:  m[KEY_LEFT]  = 1'b1;
        SC_RIGHT: m[KEY_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/keyboard_tracker_if.sv
// Received-byte stream from the PS/2 receiver to the key decoder.
interface keyboard_tracker_if;
  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

// File: rtl/keyboard_tracker_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the lines, shifts in 11-bit frames
// and emits each byte with a one-cycle valid when start/parity/stop check out.
module keyboard_tracker_ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  keyboard_tracker_if.master rx
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(10);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_prev;
  logic [10:0]      frame;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  idle_cnt;

  logic        fall_c;
  logic [10:0] frame_nxt_c;
  logic        frame_ok_c;

  assign fall_c      = clk_prev & ~clk_sync[1];
  assign frame_nxt_c = {dat_sync[1], frame[10:1]};
  assign frame_ok_c  = ~frame_nxt_c[0] & frame_nxt_c[10] & (^frame_nxt_c[9:1]);

  // Two-flop synchronizers plus the delayed clock for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  // Frame assembly; a high line on the first edge is not a start bit and is skipped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      rx.data  <= '0;
      rx.valid <= 1'b0;
    end else begin
      rx.valid <= 1'b0;
      if (fall_c) begin
        idle_cnt <= '0;
        if (bit_cnt == '0 && dat_sync[1]) begin
          bit_cnt <= '0;
        end else if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx.valid <= frame_ok_c;
          rx.data  <= frame_nxt_c[8:1];
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          frame   <= frame_nxt_c;
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == TO_LAST) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/keyboard_tracker.sv
// PS/2 keyboard front end: tracks W/A/S/D, arrows, Space and Enter as
// held levels or one-clock press pulses for the game logic.
module keyboard_tracker
  import keyboard_tracker_pkg::*;
#(
  parameter bit          PULSE_OR_HOLD  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  output logic w,
  output logic a,
  output logic s,
  output logic d,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic space,
  output logic enter
);

  // Receive-only: the keyboard owns both lines
  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;

  keyboard_tracker_if rx_bus ();

  keyboard_tracker_ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ps2_rx (
    .clock  (clock),
    .reset  (reset),
    .ps2_clk(PS2_CLK),
    .ps2_dat(PS2_DAT),
    .rx     (rx_bus.master)
  );

  prefix_t  prefix;
  key_vec_t pressed;
  key_vec_t pulse;
  key_vec_t hit_c;
  key_vec_t status_c;

  assign hit_c = key_mask(rx_bus.data, prefix.ext);

  // Prefix decoder and per-key pressed/pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prefix  <= '0;
      pressed <= '0;
      pulse   <= '0;
    end else begin
      pulse <= '0;
      if (rx_bus.valid) begin
        if (rx_bus.data == SC_EXT) begin
          prefix.ext <= 1'b1;
        end else if (rx_bus.data == SC_BRK) begin
          prefix.brk <= 1'b1;
        end else begin
          prefix <= '0;
          if (prefix.brk) begin
            pressed <= pressed & ~hit_c;
          end else begin
            pressed <= pressed | hit_c;
            pulse   <= hit_c & ~pressed;
          end
        end
      end
    end
  end

  assign status_c = PULSE_OR_HOLD ? pulse : pressed;

  assign w     = status_c[KEY_W];
  assign a     = status_c[KEY_A];
  assign s     = status_c[KEY_S];
  assign d     = status_c[KEY_D];
  assign left  = status_c[KEY_LEFT];
  assign right = status_c[KEY_RIGHT];
  assign up    = status_c[KEY_UP];
  assign down  = status_c[KEY_DOWN];
  assign space = status_c[KEY_SPACE];
  assign enter = status_c[KEY_ENTER];

endmodule

// File: tb/tb_keyboard_tracker.sv
// Directed bench: one hold-mode and one pulse-mode tracker share the same
// PS/2 stimulus; key vectors are {enter,space,down,up,right,left,d,s,a,w}.
module tb_keyboard_tracker;

  localparam int unsigned TO  = 200;
  localparam int          H   = 20;
  localparam int          GAP = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_d = 1'b1;
  logic ps2_dat_d = 1'b1;
  wire  ps2_clk;
  wire  ps2_dat;
  assign ps2_clk = ps2_clk_d;
  assign ps2_dat = ps2_dat_d;

  always #10 clock = ~clock;

  logic h_w, h_a, h_s, h_d, h_left, h_right, h_up, h_down, h_space, h_enter;
  logic p_w, p_a, p_s, p_d, p_left, p_right, p_up, p_down, p_space, p_enter;

  wire [9:0] hk = {h_enter, h_space, h_down, h_up, h_right, h_left, h_d, h_s, h_a, h_w};
  wire [9:0] pk = {p_enter, p_space, p_down, p_up, p_right, p_left, p_d, p_s, p_a, p_w};

  keyboard_tracker #(.PULSE_OR_HOLD(1'b0), .TIMEOUT_CYCLES(TO)) u_hold (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .w(h_w), .a(h_a), .s(h_s), .d(h_d), .left(h_left), .right(h_right),
    .up(h_up), .down(h_down), .space(h_space), .enter(h_enter)
  );

  keyboard_tracker #(.PULSE_OR_HOLD(1'b1), .TIMEOUT_CYCLES(TO)) u_pulse (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .w(p_w), .a(p_a), .s(p_s), .d(p_d), .left(p_left), .right(p_right),
    .up(p_up), .down(p_down), .space(p_space), .enter(p_enter)
  );

  int checks = 0;
  int errors = 0;
  int enter_pulses = 0;
  int base = 0;

  always @(posedge clock) if (p_enter === 1'b1) enter_pulses <= enter_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic drive_bit(input logic b);
    @(negedge clock);
    ps2_dat_d = b;
    repeat (H) @(negedge clock);
    ps2_clk_d = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk_d = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) drive_bit(f[i]);
    @(negedge clock);
    ps2_dat_d = 1'b1;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(make_frame(b, 1'b0, 1'b0), 11);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [10:0] f;

    // Reset state
    repeat (4) @(negedge clock);
    check("reset_hold", 32'(hk), 32'h000);
    check("reset_pulse", 32'(pk), 32'h000);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // W make with cycle-accurate latency around the stop-bit fall
    f = make_frame(8'h1D, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive_bit(f[i]);
    @(negedge clock);
    ps2_dat_d = f[10];
    repeat (H) @(negedge clock);
    ps2_clk_d = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("w_lat_early", 32'(hk), 32'h000);
    @(posedge clock);
    #1 check("w_lat_hold", 32'(hk), 32'h001);
    check("w_lat_pulse", 32'(pk), 32'h001);
    @(posedge clock);
    #1 check("w_pulse_end", 32'(pk), 32'h000);
    check("w_still_held", 32'(hk), 32'h001);
    repeat (H) @(negedge clock);
    ps2_clk_d = 1'b1;
    repeat (GAP) @(negedge clock);

    send_byte(8'hF0); send_byte(8'h1D);
    check("w_break", 32'(hk), 32'h000);

    // Extended arrows
    send_byte(8'hE0); send_byte(8'h75);
    check("up_make", 32'(hk), 32'h040);
    send_byte(8'h75);
    check("keypad8_ignored", 32'(hk), 32'h040);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("up_break", 32'(hk), 32'h000);
    send_byte(8'h75);
    check("keypad8_no_set", 32'(hk), 32'h000);

    // Pulse mode with typematic repeats
    base = enter_pulses;
    send_byte(8'h5A);
    check("enter_hold", 32'(hk), 32'h200);
    send_byte(8'h5A); send_byte(8'h5A);
    check("enter_one_pulse", 32'(enter_pulses - base), 32'd1);
    check("enter_pulse_low", 32'(pk), 32'h000);
    send_byte(8'hF0); send_byte(8'h5A);
    check("enter_break", 32'(hk), 32'h000);
    check("enter_no_break_pulse", 32'(enter_pulses - base), 32'd1);
    send_byte(8'h5A);
    check("enter_second_pulse", 32'(enter_pulses - base), 32'd2);
    send_byte(8'hF0); send_byte(8'h5A);

    // Corrupted frames are dropped
    send_frame(make_frame(8'h1C, 1'b1, 1'b0), 11);
    check("bad_parity", 32'(hk), 32'h000);
    send_frame(make_frame(8'h1C, 1'b0, 1'b1), 11);
    check("bad_stop", 32'(hk), 32'h000);
    send_byte(8'h1C);
    check("a_after_bad", 32'(hk), 32'h002);
    send_byte(8'hF0); send_byte(8'h1C);

    // Partial frame abandoned by timeout
    send_frame(make_frame(8'h29, 1'b0, 1'b0), 5);
    repeat (TO + 100) @(negedge clock);
    check("partial_no_key", 32'(hk), 32'h000);
    send_byte(8'h29);
    check("space_after_timeout", 32'(hk), 32'h100);
    send_byte(8'hF0); send_byte(8'h29);
    check("space_break", 32'(hk), 32'h000);

    // Asynchronous reset mid-frame with keys held
    send_byte(8'h1D);
    send_byte(8'hE0); send_byte(8'h6B);
    check("w_left_held", 32'(hk), 32'h011);
    f = make_frame(8'h1B, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(f[i]);
    @(negedge clock);
    ps2_dat_d = 1'b1;
    #2 reset = 1'b1;
    #1 check("async_reset_hold", 32'(hk), 32'h000);
    check("async_reset_pulse", 32'(pk), 32'h000);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    send_byte(8'h23);
    check("d_after_reset", 32'(hk), 32'h008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
